// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I definitions for the front end: datapath width,
//                the canonical NOP encoding (addi x0,x0,0) and the fetch
//                buffer entry type {pc, instr}.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Bundles the instruction-memory read port and the
//                decode-facing handshake of the fetch stage.
//                Ports (named from the fetch stage's point of view):
//                  o_imem_raddr/o_imem_ren  : imem read request
//                  i_imem_rdata             : imem read data (1 cycle later)
//                  i_stall/i_redirect/i_redirect_pc : downstream control
//                  o_instr/o_pc/o_pc_plus4/o_valid/o_misaligned : head entry
//                modport master : the fetch stage
//                modport slave  : imem + decode side
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] o_imem_raddr;
    logic            o_imem_ren;
    logic [XLEN-1:0] i_imem_rdata;
    logic            i_stall;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus4;
    logic            o_valid;
    logic            o_misaligned;

    modport master (
        output o_imem_raddr, o_imem_ren, o_instr, o_pc, o_pc_plus4,
               o_valid, o_misaligned,
        input  i_imem_rdata, i_stall, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_raddr, o_imem_ren, o_instr, o_pc, o_pc_plus4,
               o_valid, o_misaligned,
        output i_imem_rdata, i_stall, i_redirect, i_redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : 2-entry FIFO of fetched {pc, instr} entries with flush.
//                Ports: i_clk, i_rst (sync, active high), i_flush (empties
//                the FIFO), i_push/i_data, i_pop, o_head (oldest entry),
//                o_count (0..2). Caller never pushes into a full FIFO
//                unless it pops in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_buffer
    import rv32i_pkg::*;
(
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    input  wire logic         i_flush,
    input  wire logic         i_push,
    input  fetch_entry_t      i_data,
    input  wire logic         i_pop,
    output fetch_entry_t      o_head,
    output logic [1:0]        o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch
//  Description : RV32I instruction fetch stage. Owns the PC, issues reads to
//                a 1-cycle synchronous imem and presents {instr, pc} to decode
//                under stall/redirect control. A 2-entry buffer plus at most
//                one in-flight read guarantees no loss or duplication.
//                Ports: i_clk, i_rst (sync, active high), bus (fetch_if
//                master: imem request/response and decode handshake).
//                Parameter RESET_ADDR: PC loaded on reset.
//                Macro FETCH_MISALIGN_TRAP_EN: when defined, a redirect to a
//                non word-aligned target raises o_misaligned and halts issue
//                until an aligned redirect or reset; when undefined the
//                target's low two bits are forced to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h00000000
)(
    input  wire logic i_clk,
    input  wire logic i_rst,
    fetch_if.master   bus
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;

    logic [XLEN-1:0] w_target;
    logic            w_halt;
    logic [1:0]      w_count;
    fetch_entry_t    w_buf_head;
    fetch_entry_t    w_resp;
    fetch_entry_t    w_head;
    logic            w_buf_nonempty;
    logic            w_valid;
    logic            w_pop;
    logic            w_buf_pop;
    logic            w_buf_push;
    logic [2:0]      w_occ;
    logic            w_issue;
    logic [XLEN-1:0] w_pc_out;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misaligned;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misaligned <= 1'b0;
        end else if (bus.i_redirect) begin
            r_misaligned <= |bus.i_redirect_pc[1:0];
        end
    end

    assign w_target = bus.i_redirect_pc;
    assign w_halt   = r_misaligned;
`else
    assign w_target = bus.i_redirect_pc & ~32'h3;
    assign w_halt   = 1'b0;
`endif

    // The response returning this cycle acts as a virtual tail entry: when
    // the buffer is empty it is presented directly to decode (bypass), so a
    // fetch issued in cycle N is visible in cycle N+1.
    assign w_resp         = '{pc: r_inflight_pc, instr: bus.i_imem_rdata};
    assign w_buf_nonempty = (w_count != 2'd0);
    assign w_valid        = w_buf_nonempty | r_inflight;
    assign w_head         = w_buf_nonempty ? w_buf_head : w_resp;

    assign w_pop      = w_valid & ~bus.i_stall & ~bus.i_redirect;
    assign w_buf_pop  = w_pop & w_buf_nonempty;
    // A bypassed response that decode consumes never enters the buffer.
    assign w_buf_push = r_inflight & ~bus.i_redirect & ~(w_pop & ~w_buf_nonempty);

    // Occupancy after this edge; a new issue is allowed only if its
    // response will still find a free slot.
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = ~i_rst & ~bus.i_redirect & ~w_halt & (w_occ < 3'd2);

    fetch_buffer u_buffer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (bus.i_redirect),
        .i_push  (w_buf_push),
        .i_data  (w_resp),
        .i_pop   (w_buf_pop),
        .o_head  (w_buf_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_ADDR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (bus.i_redirect) begin
            // Nothing is issued in the redirect cycle, so clearing the
            // in-flight flag squashes any older response.
            r_pc       <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
        end
    end

    // While trapped, r_pc holds the offending target and is reported.
    assign w_pc_out = w_valid ? w_head.pc : (w_halt ? r_pc : '0);

    assign bus.o_imem_raddr = r_pc;
    assign bus.o_imem_ren   = w_issue;
    assign bus.o_valid      = w_valid;
    assign bus.o_instr      = w_valid ? w_head.instr : NOP_INSTR;
    assign bus.o_pc         = w_pc_out;
    assign bus.o_pc_plus4   = w_pc_out + 32'd4;
    assign bus.o_misaligned = w_halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch
//  Description : Self-checking bench for the fetch stage. Per-cycle vectors
//                give inputs and expected request/head outputs; every
//                expected issue is queued with its imem data and popped when
//                decode consumes an instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch;
    import rv32i_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] raddr;
        logic        chk;
        logic        valid;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [63:0] sb [$];
    vec_t vt [$];

    always #5 clk = ~clk;

    fetch_if u_if ();

    fetch #(.RESET_ADDR(32'h00000000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h00A00093;
    endfunction

    // Synchronous imem model
    always @(posedge clk) begin
        if (rst) u_if.i_imem_rdata <= 32'h0;
        else if (u_if.o_imem_ren) u_if.i_imem_rdata <= imem_word(u_if.o_imem_raddr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, got, exp);
    endtask

    // Scoreboard consumer: every instruction decode accepts must be the
    // oldest outstanding expected fetch.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && u_if.o_valid && !u_if.i_stall && !u_if.i_redirect) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got pc %08h expected no instruction", u_if.o_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", u_if.o_pc, e[63:32]);
                check("sb_instr", u_if.o_instr, e[31:0]);
            end
        end
    end

    function automatic vec_t V(input logic rst_, input logic stall_, input logic redir_,
                               input logic [31:0] rpc_, input logic ren_, input logic [31:0] raddr_,
                               input logic chk_, input logic valid_, input logic [31:0] pc_,
                               input logic mis_);
        vec_t v;
        v.rst = rst_; v.stall = stall_; v.redir = redir_; v.rpc = rpc_;
        v.ren = ren_; v.raddr = raddr_; v.chk = chk_; v.valid = valid_;
        v.pc = pc_; v.mis = mis_;
        return v;
    endfunction

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst              = v.rst;
        u_if.i_stall       = v.stall;
        u_if.i_redirect    = v.redir;
        u_if.i_redirect_pc = v.rpc;
        if (v.rst || v.redir) sb.delete();
        if (v.ren) sb.push_back({v.raddr, imem_word(v.raddr)});
        @(negedge clk);
        check("imem_ren", {31'd0, u_if.o_imem_ren}, {31'd0, v.ren});
        if (v.ren) check("imem_raddr", u_if.o_imem_raddr, v.raddr);
        check("misaligned", {31'd0, u_if.o_misaligned}, {31'd0, v.mis});
        if (v.chk) begin
            check("valid", {31'd0, u_if.o_valid}, {31'd0, v.valid});
            check("pc", u_if.o_pc, v.pc);
            if (v.valid) check("pc_plus4", u_if.o_pc_plus4, v.pc + 32'd4);
            else         check("instr_nop", u_if.o_instr, NOP_INSTR);
        end
    endtask

    initial begin
        u_if.i_stall       = 1'b0;
        u_if.i_redirect    = 1'b0;
        u_if.i_redirect_pc = 32'h0;

        // reset, then straight-line fetch
        vt.push_back(V(1,0,0,0,           0,0,           0,0,0,           0));
        vt.push_back(V(1,0,0,0,           0,0,           1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h0,       1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h4,       1,1,32'h0,       0));
        vt.push_back(V(0,0,0,0,           1,32'h8,       1,1,32'h4,       0));
        // stall five cycles at pc 8
        vt.push_back(V(0,1,0,0,           1,32'hC,       1,1,32'h8,       0));
        vt.push_back(V(0,1,0,0,           0,0,           1,1,32'h8,       0));
        vt.push_back(V(0,1,0,0,           0,0,           1,1,32'h8,       0));
        vt.push_back(V(0,1,0,0,           0,0,           1,1,32'h8,       0));
        vt.push_back(V(0,1,0,0,           0,0,           1,1,32'h8,       0));
        vt.push_back(V(0,0,0,0,           1,32'h10,      1,1,32'h8,       0));
        vt.push_back(V(0,0,0,0,           1,32'h14,      1,1,32'hC,       0));
        vt.push_back(V(0,0,0,0,           1,32'h18,      1,1,32'h10,      0));
        // redirect with one buffered entry and one in flight
        vt.push_back(V(0,0,1,32'h100,     0,0,           0,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h100,     1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h104,     1,1,32'h100,     0));
        // fill buffer under stall, then redirect while stalled and full
        vt.push_back(V(0,1,0,0,           1,32'h108,     1,1,32'h104,     0));
        vt.push_back(V(0,1,0,0,           0,0,           1,1,32'h104,     0));
        vt.push_back(V(0,1,1,32'h100,     0,0,           0,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h100,     1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h104,     1,1,32'h100,     0));
        // wrap at the top of the address space
        vt.push_back(V(0,0,1,32'hFFFFFFFC,0,0,           0,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'hFFFFFFFC,1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h0,       1,1,32'hFFFFFFFC,0));
        vt.push_back(V(0,0,0,0,           1,32'h4,       1,1,32'h0,       0));
        // misaligned redirect target
        vt.push_back(V(0,0,1,32'h102,     0,0,           0,0,0,           0));
`ifdef FETCH_MISALIGN_TRAP_EN
        vt.push_back(V(0,0,0,0,           0,0,           1,0,32'h102,     1));
        vt.push_back(V(0,0,0,0,           0,0,           1,0,32'h102,     1));
        vt.push_back(V(0,0,1,32'h200,     0,0,           0,0,0,           1));
`else
        vt.push_back(V(0,0,0,0,           1,32'h100,     1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h104,     1,1,32'h100,     0));
        vt.push_back(V(0,0,1,32'h200,     0,0,           0,0,0,           0));
`endif
        vt.push_back(V(0,0,0,0,           1,32'h200,     1,0,0,           0));
        vt.push_back(V(0,0,0,0,           1,32'h204,     1,1,32'h200,     0));
        vt.push_back(V(0,1,0,0,           1,32'h208,     1,1,32'h204,     0));

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // reset mid-operation: buffered entry and in-flight read discarded
        step(V(1,0,0,0, 0,0,     0,0,0,     0));
        step(V(1,0,0,0, 0,0,     1,0,0,     0));
        step(V(0,0,0,0, 1,32'h0, 1,0,0,     0));
        step(V(0,0,0,0, 1,32'h4, 1,1,32'h0, 0));
        step(V(0,0,0,0, 1,32'h8, 1,1,32'h4, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
